// File: rtl/xex_arbiter.sv
// Two-requester round-robin front end for one shared xexaes256 engine: accept, issue, wait under watchdog, respond.
// Issue one cycle after accept. Response from the cycle after the engine strobe. One job in flight; no new grant until the response handshake.
module xex_arbiter #(
  parameter int TIMEOUT = 1023,
  parameter int TO_W    = 16
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         a_req_valid,
  output logic         a_req_ready,
  input  logic [1:0]   a_mode,
  input  logic [127:0] a_sector,
  input  logic [127:0] a_data,
  output logic         a_resp_valid,
  input  logic         a_resp_ready,
  output logic [127:0] a_resp_data,
  output logic         a_resp_err,
  input  logic         b_req_valid,
  output logic         b_req_ready,
  input  logic [1:0]   b_mode,
  input  logic [127:0] b_sector,
  input  logic [127:0] b_data,
  output logic         b_resp_valid,
  input  logic         b_resp_ready,
  output logic [127:0] b_resp_data,
  output logic         b_resp_err,
  output logic         eng_in_rdy,
  output logic [1:0]   eng_mode,
  output logic [127:0] eng_sector,
  output logic [127:0] eng_data_in,
  input  logic         eng_busy,
  input  logic         eng_out_rdy,
  input  logic [127:0] eng_data_out,
  output logic         arb_busy,
  output logic         owner
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          state, state_nxt;
  logic            rr;
  logic [TO_W-1:0] timer;
  logic            grant_b;
  logic            accept;
  logic            resp_hs;
  logic            timeout_hit;
  logic            wait_done;

  // rr=1 hands a contested grant to B.
  assign grant_b     = b_req_valid & (~a_req_valid | rr);
  assign accept      = (state == S_IDLE) & (a_req_valid | b_req_valid);
  assign resp_hs     = (state == S_RESP) & (owner ? b_resp_ready : a_resp_ready);
  assign timeout_hit = (timer == TO_W'(TIMEOUT));
  assign wait_done   = (state == S_WAIT) & (eng_out_rdy | timeout_hit);

  always_ff @(posedge clk) begin
    if (!n_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept)                      state_nxt = S_ISSUE;
      S_ISSUE: if (!eng_busy)                   state_nxt = S_WAIT;
      S_WAIT:  if (eng_out_rdy || timeout_hit)  state_nxt = S_RESP;
      S_RESP:  if (resp_hs)                     state_nxt = S_IDLE;
      default:                                  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    a_req_ready  = 1'b0;
    b_req_ready  = 1'b0;
    eng_in_rdy   = 1'b0;
    a_resp_valid = 1'b0;
    b_resp_valid = 1'b0;
    arb_busy     = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        a_req_ready = a_req_valid & ~grant_b;
        b_req_ready = grant_b;
      end
      S_ISSUE: eng_in_rdy = ~eng_busy;
      S_RESP: begin
        a_resp_valid = ~owner;
        b_resp_valid = owner;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      eng_mode    <= '0;
      eng_sector  <= '0;
      eng_data_in <= '0;
      owner       <= 1'b0;
      rr          <= 1'b0;
      timer       <= '0;
      a_resp_data <= '0;
      a_resp_err  <= 1'b0;
      b_resp_data <= '0;
      b_resp_err  <= 1'b0;
    end else begin
      if (accept) begin
        owner       <= grant_b;
        eng_mode    <= grant_b ? b_mode   : a_mode;
        eng_sector  <= grant_b ? b_sector : a_sector;
        eng_data_in <= grant_b ? b_data   : a_data;
      end
      if (state == S_ISSUE)     timer <= '0;
      else if (state == S_WAIT) timer <= timer + TO_W'(1);
      // A real engine result beats a same-cycle timeout.
      if (wait_done) begin
        if (owner) begin
          b_resp_data <= eng_out_rdy ? eng_data_out : '0;
          b_resp_err  <= ~eng_out_rdy;
        end else begin
          a_resp_data <= eng_out_rdy ? eng_data_out : '0;
          a_resp_err  <= ~eng_out_rdy;
        end
      end
      if (resp_hs) rr <= ~owner;
    end
  end

endmodule

// File: tb/tb_xex_arbiter.sv
// Bench for xex_arbiter: a directed job table, a mid-job reset sequence and random jobs checked against a
// grant-history model of the round-robin rule.
module tb_xex_arbiter;
  localparam int TIMEOUT = 8;
  localparam int TO_W    = 16;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         a_req_valid, a_req_ready, a_resp_valid, a_resp_ready, a_resp_err;
  logic [1:0]   a_mode;
  logic [127:0] a_sector, a_data, a_resp_data;
  logic         b_req_valid, b_req_ready, b_resp_valid, b_resp_ready, b_resp_err;
  logic [1:0]   b_mode;
  logic [127:0] b_sector, b_data, b_resp_data;
  logic         eng_in_rdy, eng_busy, eng_out_rdy, arb_busy, owner;
  logic [1:0]   eng_mode;
  logic [127:0] eng_sector, eng_data_in, eng_data_out;

  xex_arbiter #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .n_rst(n_rst),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_mode(a_mode), .a_sector(a_sector),
    .a_data(a_data), .a_resp_valid(a_resp_valid), .a_resp_ready(a_resp_ready),
    .a_resp_data(a_resp_data), .a_resp_err(a_resp_err),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_mode(b_mode), .b_sector(b_sector),
    .b_data(b_data), .b_resp_valid(b_resp_valid), .b_resp_ready(b_resp_ready),
    .b_resp_data(b_resp_data), .b_resp_err(b_resp_err),
    .eng_in_rdy(eng_in_rdy), .eng_mode(eng_mode), .eng_sector(eng_sector),
    .eng_data_in(eng_data_in), .eng_busy(eng_busy), .eng_out_rdy(eng_out_rdy),
    .eng_data_out(eng_data_out), .arb_busy(arb_busy), .owner(owner)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  bit served_q[$];

  typedef struct {
    bit           av;
    bit           bv;
    int           busy;
    int           lat;
    int           bp;
    logic [127:0] res;
    bit           own;
    bit           err;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Winner from the grant history: a lone requester wins; a contest goes to whoever was not served last.
  function automatic bit model_winner(input bit av, input bit bv);
    if (av && !bv) return 1'b0;
    if (bv && !av) return 1'b1;
    if (served_q.size() == 0) return 1'b0;
    return !served_q[$];
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_arb_busy"}, arb_busy, 0);
    chk({tag, "_owner"}, owner, 0);
    chk({tag, "_eng_in_rdy"}, eng_in_rdy, 0);
    chk({tag, "_eng_mode"}, eng_mode, 0);
    chk({tag, "_eng_sector"}, eng_sector, 0);
    chk({tag, "_eng_data_in"}, eng_data_in, 0);
    chk({tag, "_a_resp"}, {a_resp_valid, a_resp_err, a_resp_data}, 0);
    chk({tag, "_b_resp"}, {b_resp_valid, b_resp_err, b_resp_data}, 0);
  endtask

  // lat = WAIT cycle (1-based) carrying the engine strobe; 0 = never, letting the watchdog fire.
  task automatic run_job(input bit av, input bit bv, input int busy, input int lat, input int bp,
                         input logic [127:0] res, input bit exp_own, input bit exp_err);
    logic [127:0] exp_data;
    int           n;
    bit           seen;
    a_req_valid  = av;
    b_req_valid  = bv;
    eng_busy     = (busy > 0);
    a_resp_ready = 1'b0;
    b_resp_ready = 1'b0;
    #1;
    chk("a_req_ready", a_req_ready, exp_own == 1'b0);
    chk("b_req_ready", b_req_ready, exp_own == 1'b1);
    step();
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    chk("owner", owner, exp_own);
    chk("arb_busy", arb_busy, 1);
    chk("eng_mode", eng_mode, exp_own ? b_mode : a_mode);
    chk("eng_sector", eng_sector, exp_own ? b_sector : a_sector);
    chk("eng_data_in", eng_data_in, exp_own ? b_data : a_data);
    for (int i = 0; i < busy; i++) begin
      chk("eng_in_rdy_busy", eng_in_rdy, 0);
      step();
    end
    eng_busy = 1'b0;
    #1;
    chk("eng_in_rdy_pulse", eng_in_rdy, 1);
    step();
    chk("eng_in_rdy_single", eng_in_rdy, 0);
    n    = 1;
    seen = 1'b0;
    while (n <= 40 && !seen) begin
      eng_out_rdy  = (n == lat);
      eng_data_out = (n == lat) ? res : {4{$urandom}};
      step();
      eng_out_rdy = 1'b0;
      if (a_resp_valid || b_resp_valid) seen = 1'b1;
      else n++;
    end
    chk("resp_latency", n, (lat > 0) ? lat : TIMEOUT + 1);
    exp_data = exp_err ? 128'h0 : res;
    chk("own_resp_valid", exp_own ? b_resp_valid : a_resp_valid, 1);
    chk("other_resp_valid", exp_own ? a_resp_valid : b_resp_valid, 0);
    chk("resp_data", exp_own ? b_resp_data : a_resp_data, exp_data);
    chk("resp_err", exp_own ? b_resp_err : a_resp_err, exp_err);
    for (int i = 0; i < bp; i++) begin
      a_req_valid  = 1'b1;
      b_req_valid  = 1'b1;
      eng_out_rdy  = 1'b1;
      eng_data_out = ~res;
      #1;
      chk("bp_no_grant", {a_req_ready, b_req_ready}, 0);
      step();
      chk("bp_valid", exp_own ? b_resp_valid : a_resp_valid, 1);
      chk("bp_data", exp_own ? b_resp_data : a_resp_data, exp_data);
    end
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
    eng_out_rdy = 1'b0;
    if (exp_own) b_resp_ready = 1'b1;
    else         a_resp_ready = 1'b1;
    step();
    a_resp_ready = 1'b0;
    b_resp_ready = 1'b0;
    chk("post_resp_idle", arb_busy, 0);
    chk("post_resp_valid", {a_resp_valid, b_resp_valid}, 0);
    served_q.push_back(exp_own);
  endtask

  initial begin
    bit av, bv;
    int lat;
    n_rst = 1'b0;
    a_req_valid = 0; b_req_valid = 0; a_resp_ready = 0; b_resp_ready = 0;
    eng_busy = 0; eng_out_rdy = 0; eng_data_out = '0;
    a_mode = 2'b01; a_sector = 128'h5;  a_data = {16{8'hAA}};
    b_mode = 2'b10; b_sector = 128'h77; b_data = {16{8'hBB}};

    tbl[0] = '{1'b1, 1'b0, 0, 9, 0, 128'h1234, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 0, 4, 0, 128'hB001, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 0, 2, 0, 128'hA002, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 0, 7, 0, 128'hB003, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 5, 3, 0, 128'hA004, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 0, 0, 0, 128'hDEAD, 1'b1, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 0, 1, 0, 128'hA006, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 0, 5, 6, 128'hB007, 1'b1, 1'b0};

    repeat (3) step();
    check_all_zero("reset");
    n_rst = 1'b1;
    #1;
    chk("reset_req_ready", {a_req_ready, b_req_ready}, 0);

    for (int i = 0; i < 8; i++)
      run_job(tbl[i].av, tbl[i].bv, tbl[i].busy, tbl[i].lat, tbl[i].bp, tbl[i].res,
              tbl[i].own, tbl[i].err);

    // Reset while B's job sits in WAIT; B was also served last, so A must win the next contest.
    b_req_valid = 1'b1;
    step();
    b_req_valid = 1'b0;
    step();
    step();
    step();
    chk("midrst_in_wait", arb_busy, 1);
    n_rst = 1'b0;
    step();
    n_rst = 1'b1;
    check_all_zero("midrst");
    served_q.delete();
    for (int i = 0; i < 12; i++) begin
      eng_out_rdy = (i == 2);
      step();
      chk("midrst_no_resp", {a_resp_valid, b_resp_valid}, 0);
    end
    eng_out_rdy = 1'b0;
    run_job(1'b1, 1'b1, 0, 3, 0, 128'hC0DE, model_winner(1'b1, 1'b1), 1'b0);

    for (int j = 0; j < 30; j++) begin
      av = 1'($urandom);
      bv = 1'($urandom);
      if (!av && !bv) av = 1'b1;
      lat = ($urandom % 6 == 0) ? 0 : int'($urandom_range(1, TIMEOUT + 1));
      a_mode = 2'($urandom); a_sector = {4{$urandom}}; a_data = {4{$urandom}};
      b_mode = 2'($urandom); b_sector = {4{$urandom}}; b_data = {4{$urandom}};
      run_job(av, bv, int'($urandom_range(0, 3)), lat, int'($urandom_range(0, 2)),
              {4{$urandom}}, model_winner(av, bv), lat == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/xex_arbiter.md
Name: xex_arbiter

Overview:
Two-requester round-robin arbiter and sequencer for a single shared xexaes256 engine. Each requester submits one 128-bit block job (mode, sector tweak, data) over a valid/ready handshake. The arbiter issues the job to the engine, waits for completion under a watchdog, and returns the result to the originating requester over a valid/ready response channel. It sits between the host-side channel logic (e.g. read path = A, write path = B) and the xexaes256 instance. The 512-bit key is wired directly to the engine and does not pass through this block.

Parameters:
TIMEOUT, 1023, max cycles in WAIT before aborting the job with an error; legal range 1..65535
TO_W, 16, watchdog counter width; must satisfy 2^TO_W > TIMEOUT

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  reset; synchronous, active-low
a_req_valid  in  1  requester A job valid
a_req_ready  out  1  A job accepted this cycle when high with a_req_valid
a_mode  in  2  A engine mode, passed through unchanged
a_sector  in  128  A sector/tweak
a_data  in  128  A data block
a_resp_valid  out  1  A result valid
a_resp_ready  in  1  A result consumed
a_resp_data  out  128  A result block
a_resp_err  out  1  A result is a watchdog abort
b_req_valid, b_req_ready, b_mode, b_sector, b_data, b_resp_valid, b_resp_ready, b_resp_data, b_resp_err: same as A, for requester B
eng_in_rdy  out  1  one-cycle start pulse to the engine
eng_mode  out  2  registered job mode
eng_sector  out  128  registered job sector
eng_data_in  out  128  registered job data
eng_busy  in  1  engine busy
eng_out_rdy  in  1  engine result strobe
eng_data_out  in  128  engine result
arb_busy  out  1  high whenever state != IDLE
owner  out  1  current/last grant: 0 = A, 1 = B

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. All transitions occur on the rising clk edge.
- Reset: when n_rst=0 at a clock edge, the block enters IDLE. Reset clears all registered outputs to 0, clears the timer, and clears the rr pointer to 0 (A preferred). Reset mid-job abandons the job; no response is produced.
- Reset-value outputs: eng_in_rdy, eng_mode, eng_sector, eng_data_in, both resp_valid/resp_data/resp_err, arb_busy and owner are all 0.
- IDLE grant (combinational):
  - If only one requester is valid, that requester is granted.
  - If both are valid, the requester selected by rr is granted (rr=0 selects A).
  - x_req_ready = (state==IDLE) & grant_x. At most one req_ready is high, and it is never high outside IDLE.
- Accept: on the handshake edge, latch the job into eng_mode/eng_sector/eng_data_in, set owner, and go to ISSUE.
- ISSUE:
  - If eng_busy=0, assert eng_in_rdy for exactly this cycle, clear the timer, and go to WAIT.
  - If eng_busy=1, hold in ISSUE with eng_in_rdy=0.
- WAIT: the timer increments each cycle.
  - eng_out_rdy=1: capture eng_data_out into owner's resp_data, set resp_err=0, go to RESP.
  - Else, timer==TIMEOUT: set resp_data=0, resp_err=1, go to RESP.
  - eng_out_rdy wins over timeout in the same cycle.
- RESP:
  - The owner's resp_valid is held high, with data and err stable, until resp_ready.
  - On the handshake edge: drop resp_valid, set rr = ~owner so the other requester has priority, go to IDLE.
  - The non-owner's resp_valid stays 0.
- eng_out_rdy outside WAIT is ignored; no state change and no capture.
- eng_mode/sector/data_in hold their value until the next accept.
- Nominal latency:
  - Accept at edge T.
  - eng_in_rdy high during cycle T+1 (if not busy).
  - eng_out_rdy in cycle W gives resp_valid from cycle W+1.
  - A new request can be accepted at the earliest one cycle after the response handshake edge.
- Throughput is one job in flight; there is no queueing.

Test Plan:
- A-only job: A valid with mode=2'b01, sector=0x5, data=0xAA..AA; engine returns 0x1234 after 10 cycles → a_req_ready for 1 cycle, eng_in_rdy for 1 cycle, a_resp_valid with data 0x1234, err=0, b_resp_valid stays 0.
- Both valid, repeated: A and B held valid for 4 jobs each → grants after reset alternate A,B,A,B,...; each response is routed only to its owner.
- Engine busy: eng_busy=1 for 5 cycles after accept → eng_in_rdy is held low, then pulses once when busy drops.
- Watchdog: TIMEOUT=8 with eng_out_rdy never asserted → resp_valid after the timer reaches 8, resp_data=0, resp_err=1; next job proceeds normally.
- Backpressure and stray strobe: hold b_resp_ready=0 for 6 cycles → b_resp_valid/data stable, no new grant; a stray eng_out_rdy during RESP does not alter the held data.
- Mid-job reset: drive n_rst=0 for one edge during WAIT → IDLE next cycle, all outputs 0, no response emitted, rr=0 (A wins the next contested grant).
